mem_dbg_reader: RTL and testbench

- Reader-side master for the data memory's debug read port (m_rf_addr → m_data), used by the DBU.
- Manual mode: inc/dec buttons browse memory one word at a time, with a live view of the word at the current address.
- Dump mode: walks addresses 0..DUMP_LAST and streams each word out over a valid/ready interface to a display or UART sink.
- Sits between the board buttons/DBU and the data memory's second read port.

---
 rtl/mem_dbg_pkg.sv | 15 +
 rtl/mem_dbg_reader_if.sv | 28 ++
 rtl/btn_sync_edge.sv | 31 +++
 rtl/mem_dbg_reader.sv | 154 +++++++++++++++
 tb/tb_mem_dbg_reader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dbg_pkg.sv
// Shared types and default widths for the data-memory debug reader.
// The optional checksum accumulator in mem_dbg_reader is enabled by defining MEM_DBG_CHECKSUM_EN.
package mem_dbg_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_dbg_reader_if.sv
// Valid/ready stream carrying dump beats (address + word) from the reader to a sink.
interface mem_dbg_reader_if
    import mem_dbg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_addr,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_addr,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A held level produces one pulse, visible three edges after the first high sample.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pulse_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse_reg <= sync2_reg & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/mem_dbg_reader.sv
// Debug read-port master: button-driven browsing of the data memory plus a full dump stream.
// Define MEM_DBG_CHECKSUM_EN to XOR-accumulate accepted dump words on the checksum output.
module mem_dbg_reader
    import mem_dbg_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DUMP_LAST = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               dec,
    input  logic               dump_start,
    input  logic [DATA_W-1:0]  m_data,
    output logic [ADDR_W-1:0]  m_rf_addr,
    output logic [DATA_W-1:0]  view_data,
    mem_dbg_reader_if.master   dump,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  checksum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_LAST);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    // Bit 0 = inc, bit 1 = dec, bit 2 = dump_start
    logic [2:0] raw_lvl;
    logic [2:0] btn_pulse;
    logic       inc_p;
    logic       dec_p;
    logic       dump_p;

    assign raw_lvl = {dump_start, dec, inc};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_sync_edge u_sync (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_lvl[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    assign inc_p  = btn_pulse[0];
    assign dec_p  = btn_pulse[1];
    assign dump_p = btn_pulse[2];

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W-1:0] saved_reg, saved_next;
    logic [DATA_W-1:0] view_reg, view_next;
    logic [ADDR_W-1:0] oaddr_reg, oaddr_next;
    logic [DATA_W-1:0] odata_reg, odata_next;
`ifdef MEM_DBG_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg, checksum_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            saved_reg <= '0;
            view_reg  <= '0;
            oaddr_reg <= '0;
            odata_reg <= '0;
`ifdef MEM_DBG_CHECKSUM_EN
            checksum_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            saved_reg <= saved_next;
            view_reg  <= view_next;
            oaddr_reg <= oaddr_next;
            odata_reg <= odata_next;
`ifdef MEM_DBG_CHECKSUM_EN
            checksum_reg <= checksum_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        saved_next = saved_reg;
        view_next  = view_reg;
        oaddr_next = oaddr_reg;
        odata_next = odata_reg;
`ifdef MEM_DBG_CHECKSUM_EN
        checksum_next = checksum_reg;
`endif
        case (state_reg)
            IDLE: begin
                view_next = m_data;
                // A dump request wins over any browse pulse arriving in the same cycle
                if (dump_p) begin
                    saved_next = ptr_reg;
                    ptr_next   = '0;
                    state_next = CAP;
`ifdef MEM_DBG_CHECKSUM_EN
                    checksum_next = '0;
`endif
                end else if (inc_p && !dec_p) begin
                    ptr_next = ptr_reg + ONE;
                end else if (dec_p && !inc_p) begin
                    ptr_next = ptr_reg - ONE;
                end
            end
            CAP: begin
                odata_next = m_data;
                oaddr_next = ptr_reg;
                state_next = OUT;
            end
            OUT: begin
                if (dump.out_ready) begin
`ifdef MEM_DBG_CHECKSUM_EN
                    checksum_next = checksum_reg ^ odata_reg;
`endif
                    if (ptr_reg == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        ptr_next   = ptr_reg + ONE;
                        state_next = CAP;
                    end
                end
            end
            DONE: begin
                ptr_next   = saved_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m_rf_addr      = ptr_reg;
    assign view_data      = view_reg;
    assign dump.out_addr  = oaddr_reg;
    assign dump.out_data  = odata_reg;
    assign dump.out_valid = (state_reg == OUT);
    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == DONE);

`ifdef MEM_DBG_CHECKSUM_EN
    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dbg_reader.sv
// Randomized self-checking bench for mem_dbg_reader against a behavioural model and beat scoreboard.
module tb_mem_dbg_reader;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LAST = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc = 1'b0;
    logic          dec = 1'b0;
    logic          dump_start = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_rf_addr;
    logic [DW-1:0] view_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic [DW-1:0] mem [256];

    mem_dbg_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dbus ();

    mem_dbg_reader #(.ADDR_W(AW), .DATA_W(DW), .DUMP_LAST(LAST)) dut (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .dec        (dec),
        .dump_start (dump_start),
        .m_data     (m_data),
        .m_rf_addr  (m_rf_addr),
        .view_data  (view_data),
        .dump       (dbus),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    assign m_data = mem[m_rf_addr];
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: address pointer, phase of the dump, expected registered outputs
    int            m_ptr = 0, m_saved = 0, m_phase = 0;   // phase 0 idle, 1 capture, 2 offer, 3 finish
    logic [DW-1:0] m_view = '0, m_odata = '0, m_cs = '0;
    int            m_oaddr = 0;
    logic [4:0]    hist_i = '0, hist_d = '0, hist_s = '0;  // raw samples, bit k = k edges ago

    // Beat scoreboard built from what the sink actually accepted
    int            sb_idx = 0, beats = 0, done_cnt = 0, busy_cyc = 0;
    logic [DW-1:0] sb_cs = '0;
    logic          pv = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(i * 4 + 'h100);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && pv && dbus.out_ready) begin
                check("beat_addr", 64'(pa), 64'(sb_idx));
                check("beat_data", 64'(pd), 64'(pa) * 4 + 64'h100);
                sb_cs ^= pd;
                sb_idx++;
                beats++;
            end
            hist_i = {hist_i[3:0], inc};
            hist_d = {hist_d[3:0], dec};
            hist_s = {hist_s[3:0], dump_start};
            if (rst) begin
                m_ptr = 0; m_saved = 0; m_phase = 0; m_view = '0;
                m_odata = '0; m_oaddr = 0; m_cs = '0;
                hist_i = '0; hist_d = '0; hist_s = '0;
            end else begin
                case (m_phase)
                    0: begin
                        m_view = mem[m_ptr];
                        // a press acts on the 4th edge after its first high sample
                        if (hist_s[3] && !hist_s[4]) begin
                            m_saved = m_ptr; m_ptr = 0; m_phase = 1; m_cs = '0;
                            sb_idx = 0; beats = 0; sb_cs = '0;
                        end else if ((hist_i[3] && !hist_i[4]) && !(hist_d[3] && !hist_d[4])) begin
                            m_ptr = (m_ptr + 1) % 256;
                        end else if ((hist_d[3] && !hist_d[4]) && !(hist_i[3] && !hist_i[4])) begin
                            m_ptr = (m_ptr + 255) % 256;
                        end
                    end
                    1: begin
                        m_odata = mem[m_ptr]; m_oaddr = m_ptr; m_phase = 2;
                    end
                    2: begin
                        if (dbus.out_ready) begin
                            m_cs ^= m_odata;
                            if (m_ptr == LAST) m_phase = 3;
                            else begin m_ptr = m_ptr + 1; m_phase = 1; end
                        end
                    end
                    default: begin
                        m_ptr = m_saved; m_phase = 0;
                    end
                endcase
            end
            check("m_rf_addr", 64'(m_rf_addr), 64'(m_ptr));
            check("view_data", 64'(view_data), 64'(m_view));
            check("busy", 64'(busy), 64'(m_phase != 0));
            check("out_valid", 64'(dbus.out_valid), 64'(m_phase == 2));
            check("done", 64'(done), 64'(m_phase == 3));
`ifdef MEM_DBG_CHECKSUM_EN
            check("checksum", 64'(checksum), 64'(m_cs));
`else
            check("checksum", 64'(checksum), 64'h0);
`endif
            if (m_phase == 2) begin
                check("out_addr", 64'(dbus.out_addr), 64'(m_oaddr));
                check("out_data", 64'(dbus.out_data), 64'(m_odata));
            end
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            pv = dbus.out_valid; pa = dbus.out_addr; pd = dbus.out_data;
        end
    end

    // Sink: always ready, random, or random with a forced 5-cycle stall on beat 10
    int ready_mode = 0;
    int hold_cnt   = 0;
    initial begin
        dbus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) begin
                dbus.out_ready = 1'b1;
            end else if (ready_mode == 2 && dbus.out_valid && dbus.out_addr == 8'd10 && hold_cnt < 5) begin
                check("hold_addr", 64'(dbus.out_addr), 64'd10);
                check("hold_data", 64'(dbus.out_data), 64'h128);
                hold_cnt++;
                dbus.out_ready = 1'b0;
            end else begin
                dbus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // mask bit0 = inc, bit1 = dec, bit2 = dump_start
    task automatic press(input int mask, input int hold);
        @(negedge clk);
        inc = mask[0]; dec = mask[1]; dump_start = mask[2];
        repeat (hold) @(negedge clk);
        inc = 1'b0; dec = 1'b0; dump_start = 1'b0;
        repeat (6) @(negedge clk);
        $display("press mask=%0d hold=%0d ptr=%0d", mask, hold, m_rf_addr);
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check(name, 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    logic [DW-1:0] exp_cs;
    int            d0;

    initial begin
        exp_cs = '0;
        for (int i = 0; i < 256; i++) exp_cs ^= DW'(i * 4 + 'h100);

        repeat (2) @(negedge clk);
        check("rst_addr", 64'(m_rf_addr), 64'd0);
        check("rst_view", 64'(view_data), 64'd0);
        check("rst_valid", 64'(dbus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        repeat (3) press(1, 2);
        check("browse_addr", 64'(m_rf_addr), 64'd3);
        check("browse_view", 64'(view_data), 64'h10C);

        // latency: pointer moves on the 4th edge after the first high sample
        @(negedge clk);
        inc = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #2;
            check(k < 4 ? "lat_before" : "lat_after", 64'(m_rf_addr), k < 4 ? 64'd3 : 64'd4);
        end
        repeat (17) @(negedge clk);
        inc = 1'b0;
        repeat (6) @(negedge clk);
        check("held_single", 64'(m_rf_addr), 64'd4);

        repeat (4) press(2, 1);
        press(2, 1);
        check("wrap_dec", 64'(m_rf_addr), 64'd255);
        check("wrap_view", 64'(view_data), 64'h4FC);
        press(1, 1);
        check("wrap_inc", 64'(m_rf_addr), 64'd0);
        press(3, 2);
        check("inc_dec_same", 64'(m_rf_addr), 64'd0);

        for (int k = 0; k < 30; k++) press(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        for (int k = 0; k < 300 && m_ptr != 7; k++) press((((7 - m_ptr) + 256) % 256) < 128 ? 1 : 2, 1);
        check("nav_to_7", 64'(m_rf_addr), 64'd7);

        // full dump, sink always ready
        ready_mode = 0; busy_cyc = 0; d0 = done_cnt;
        press(4, 1);
        wait_done(d0, "dump1_timeout");
        $display("dump1 beats=%0d busy_cycles=%0d", beats, busy_cyc);
        check("dump1_beats", 64'(beats), 64'd256);
        check("dump1_done_once", 64'(done_cnt - d0), 64'd1);
        check("dump1_cadence", 64'(busy_cyc), 64'd513);
        check("dump1_restore", 64'(m_rf_addr), 64'd7);
        check("dump1_sb_cs", 64'(sb_cs), 64'(exp_cs));
`ifdef MEM_DBG_CHECKSUM_EN
        check("dump1_checksum", 64'(checksum), 64'(exp_cs));
`else
        check("dump1_checksum", 64'(checksum), 64'd0);
`endif

        // backpressure dump with presses that must be ignored
        ready_mode = 2; hold_cnt = 0; d0 = done_cnt;
        press(4, 1);
        press(1, 2);
        press(4, 2);
        press(2, 1);
        wait_done(d0, "dump2_timeout");
        $display("dump2 beats=%0d stall_cycles=%0d", beats, hold_cnt);
        check("dump2_beats", 64'(beats), 64'd256);
        check("dump2_stall", 64'(hold_cnt), 64'd5);
        check("dump2_restore", 64'(m_rf_addr), 64'd7);

        // abort with reset during beat 50
        ready_mode = 0; d0 = done_cnt;
        press(4, 1);
        for (int n = 0; n < 600 && !(dbus.out_valid && dbus.out_addr == 8'd50); n++) @(negedge clk);
        check("abort_reached", 64'(dbus.out_addr), 64'd50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(dbus.out_valid), 64'd0);
        check("abort_addr", 64'(m_rf_addr), 64'd0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        $display("abort at beat 50 ptr=%0d", m_rf_addr);

        // random-ready dump from ptr 0
        ready_mode = 1; d0 = done_cnt;
        press(4, 1);
        wait_done(d0, "dump3_timeout");
        $display("dump3 beats=%0d", beats);
        check("dump3_beats", 64'(beats), 64'd256);
        check("dump3_restore", 64'(m_rf_addr), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
